// File: rtl/sched_pkg.sv
// Shared command/state encodings and default timing for the bank command sequencer.
package sched_pkg;

    typedef enum logic [1:0] {
        OP_ACT = 2'd0,
        OP_RD  = 2'd1,
        OP_WR  = 2'd2,
        OP_PRE = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ACTIVATING  = 2'd1,
        ST_ACTIVE      = 2'd2,
        ST_PRECHARGING = 2'd3
    } bank_state_e;

    localparam int unsigned DEF_TRCD = 3;
    localparam int unsigned DEF_TRP  = 3;
    localparam int unsigned DEF_TRAS = 6;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bank_fsm.sv
// Per-bank state machine with activate/precharge phase timer and tRAS guard counter.
module bank_fsm
    import sched_pkg::*;
#(
    parameter int unsigned COLWIDTH = 10,
    parameter int unsigned CHWIDTH  = 5,
    parameter int unsigned TRCD     = DEF_TRCD,
    parameter int unsigned TRP      = DEF_TRP,
    parameter int unsigned TRAS     = DEF_TRAS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  cmd_op_e             op,
    input  logic [CHWIDTH-1:0]  cmd_row,
    input  logic [COLWIDTH-1:0] cmd_col,
    output bank_state_e         state,
    output logic                tras_zero,
    output logic [CHWIDTH-1:0]  row,
    output logic [COLWIDTH-1:0] column,
    output logic                rd_o_wr,
    output logic                bank_open
);

    localparam int unsigned TMAX = max3(TRCD, TRP, TRAS);
    localparam int unsigned CW   = $clog2(TMAX + 1);

    logic [CW-1:0] tmr;
    logic [CW-1:0] tras_cnt;

    assign tras_zero = (tras_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            tras_cnt  <= '0;
            row       <= '0;
            column    <= '0;
            rd_o_wr   <= 1'b0;
            bank_open <= 1'b0;
        end else begin
            // tRAS guard runs from ACT acceptance until it saturates
            if (!tras_zero && (state == ST_ACTIVATING || state == ST_ACTIVE))
                tras_cnt <= tras_cnt - CW'(1);

            unique case (state)
                ST_IDLE: begin
                    if (sel && op == OP_ACT) begin
                        state    <= ST_ACTIVATING;
                        row      <= cmd_row;
                        tmr      <= CW'(TRCD);
                        tras_cnt <= CW'(TRAS);
                    end
                end
                ST_ACTIVATING: begin
                    if (tmr <= CW'(1)) begin
                        state     <= ST_ACTIVE;
                        tmr       <= '0;
                        bank_open <= 1'b1;
                    end else begin
                        tmr <= tmr - CW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (sel) begin
                        case (op)
                            OP_RD: begin
                                column  <= cmd_col;
                                rd_o_wr <= 1'b0;
                            end
                            OP_WR: begin
                                column  <= cmd_col;
                                rd_o_wr <= 1'b1;
                            end
                            OP_PRE: begin
                                state     <= ST_PRECHARGING;
                                tmr       <= CW'(TRP);
                                bank_open <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PRECHARGING: begin
                    if (tmr <= CW'(1)) begin
                        state <= ST_IDLE;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bank_cmd_sequencer.sv
// Bank command sequencer: steers ACT/RD/WR/PRE commands to per-bank FSMs and flags illegal ones.
// Optional activity counters are built when BANK_CMD_SEQUENCER_STATS_EN is defined.
module bank_cmd_sequencer
    import sched_pkg::*;
#(
    parameter int unsigned BGWIDTH  = 2,
    parameter int unsigned BAWIDTH  = 2,
    parameter int unsigned COLWIDTH = 10,
    parameter int unsigned CHWIDTH  = 5,
    parameter int unsigned TRCD     = DEF_TRCD,
    parameter int unsigned TRP      = DEF_TRP,
    parameter int unsigned TRAS     = DEF_TRAS,
    localparam int unsigned BANKGROUPS    = 1 << BGWIDTH,
    localparam int unsigned BANKSPERGROUP = 1 << BAWIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [BGWIDTH-1:0]  cmd_bg,
    input  logic [BAWIDTH-1:0]  cmd_ba,
    input  logic [CHWIDTH-1:0]  cmd_row,
    input  logic [COLWIDTH-1:0] cmd_col,
    output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]               rd_o_wr,
    output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]  row,
    output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][COLWIDTH-1:0] column,
    output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]               bank_open,
    output logic                err
`ifdef BANK_CMD_SEQUENCER_STATS_EN
    ,
    output logic [31:0]         act_cnt,
    output logic [31:0]         rd_cnt,
    output logic [31:0]         wr_cnt,
    output logic [31:0]         err_cnt
`endif
);

    cmd_op_e     op;
    bank_state_e [BANKGROUPS-1:0][BANKSPERGROUP-1:0] bank_state;
    logic        [BANKGROUPS-1:0][BANKSPERGROUP-1:0] tras_zero;
    bank_state_e tgt_state;
    logic        tgt_tras_zero;
    logic        accept;
    logic        illegal;

    assign op            = cmd_op_e'(cmd_op);
    assign tgt_state     = bank_state[cmd_bg][cmd_ba];
    assign tgt_tras_zero = tras_zero[cmd_bg][cmd_ba];

    // Back-pressure while the target bank is mid-transition or still inside tRAS
    always_comb begin
        cmd_ready = 1'b1;
        if (rst)
            cmd_ready = 1'b0;
        else if (tgt_state == ST_ACTIVATING || tgt_state == ST_PRECHARGING)
            cmd_ready = 1'b0;
        else if (op == OP_PRE && !tgt_tras_zero)
            cmd_ready = 1'b0;
    end

    assign accept  = cmd_valid && cmd_ready;
    assign illegal = (op == OP_ACT && tgt_state != ST_IDLE) ||
                     ((op == OP_RD || op == OP_WR) && tgt_state != ST_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= accept && illegal;
    end

    for (genvar g = 0; g < BANKGROUPS; g++) begin : g_bg
        for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_ba
            logic sel;
            assign sel = accept && (cmd_bg == BGWIDTH'(g)) && (cmd_ba == BAWIDTH'(b));

            bank_fsm #(
                .COLWIDTH (COLWIDTH),
                .CHWIDTH  (CHWIDTH),
                .TRCD     (TRCD),
                .TRP      (TRP),
                .TRAS     (TRAS)
            ) u_bank (
                .clk       (clk),
                .rst       (rst),
                .sel       (sel),
                .op        (op),
                .cmd_row   (cmd_row),
                .cmd_col   (cmd_col),
                .state     (bank_state[g][b]),
                .tras_zero (tras_zero[g][b]),
                .row       (row[g][b]),
                .column    (column[g][b]),
                .rd_o_wr   (rd_o_wr[g][b]),
                .bank_open (bank_open[g][b])
            );
        end
    end

`ifdef BANK_CMD_SEQUENCER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            act_cnt <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (accept && op == OP_ACT)                               act_cnt <= act_cnt + 32'd1;
            if (accept && op == OP_RD && tgt_state == ST_ACTIVE)      rd_cnt  <= rd_cnt + 32'd1;
            if (accept && op == OP_WR && tgt_state == ST_ACTIVE)      wr_cnt  <= wr_cnt + 32'd1;
            if (err)                                                  err_cnt <= err_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bank_cmd_sequencer.sv
// Scoreboard bench for bank_cmd_sequencer: timestamp-based bank model feeds an expected-output queue.
module tb_bank_cmd_sequencer;

    localparam int unsigned BGW  = 2;
    localparam int unsigned BAW  = 2;
    localparam int unsigned COLW = 10;
    localparam int unsigned CHW  = 5;
    localparam int unsigned NBG  = 4;
    localparam int unsigned NBA  = 4;
    localparam int TRCD = 3;
    localparam int TRP  = 3;
    localparam int TRAS = 6;

    localparam int S_IDLE = 0, S_OPENING = 1, S_OPEN = 2, S_CLOSING = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [BGW-1:0] cmd_bg = '0;
    logic [BAW-1:0] cmd_ba = '0;
    logic [CHW-1:0] cmd_row = '0;
    logic [COLW-1:0] cmd_col = '0;
    logic [NBG-1:0][NBA-1:0]           rd_o_wr;
    logic [NBG-1:0][NBA-1:0][CHW-1:0]  row;
    logic [NBG-1:0][NBA-1:0][COLW-1:0] column;
    logic [NBG-1:0][NBA-1:0]           bank_open;
    logic err;

    bank_cmd_sequencer #(
        .BGWIDTH(BGW), .BAWIDTH(BAW), .COLWIDTH(COLW), .CHWIDTH(CHW),
        .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .rd_o_wr(rd_o_wr), .row(row), .column(column),
        .bank_open(bank_open), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                              err;
        logic [NBG-1:0][NBA-1:0]           open;
        logic [NBG-1:0][NBA-1:0][CHW-1:0]  row;
        logic [NBG-1:0][NBA-1:0][COLW-1:0] col;
        logic [NBG-1:0][NBA-1:0]           rdwr;
    } snap_t;

    snap_t q[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model: each bank is described by when it was last activated / precharged
    bit m_open [NBG][NBA];
    int m_tact [NBG][NBA];
    int m_tpre [NBG][NBA];
    logic [NBG-1:0][NBA-1:0][CHW-1:0]  m_row;
    logic [NBG-1:0][NBA-1:0][COLW-1:0] m_col;
    logic [NBG-1:0][NBA-1:0]           m_rdwr;
    int edge_n = 0;

    function automatic int mstat(input int g, input int b);
        if (m_open[g][b]) return (edge_n < m_tact[g][b] + TRCD) ? S_OPENING : S_OPEN;
        return (edge_n < m_tpre[g][b] + TRP) ? S_CLOSING : S_IDLE;
    endfunction

    function automatic bit tras_done(input int g, input int b);
        return !m_open[g][b] || (edge_n >= m_tact[g][b] + TRAS);
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NBG; g++)
            for (int b = 0; b < NBA; b++) begin
                m_open[g][b] = 1'b0;
                m_tact[g][b] = -100;
                m_tpre[g][b] = -100;
            end
        m_row  = '0;
        m_col  = '0;
        m_rdwr = '0;
    endtask

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check ready against model, advance model, queue expected outputs
    task automatic step(input bit r, input bit v, input int op, input int g, input int b,
                        input int rw, input int cl, output bit acc);
        int st;
        bit rdy;
        bit e;
        snap_t s;
        rst = r; cmd_valid = v; cmd_op = 2'(op);
        cmd_bg = BGW'(g); cmd_ba = BAW'(b); cmd_row = CHW'(rw); cmd_col = COLW'(cl);
        #1;
        st  = mstat(g, b);
        rdy = !r && st != S_OPENING && st != S_CLOSING && !(op == 3 && !tras_done(g, b));
        chk("cmd_ready", 256'(cmd_ready), 256'(rdy));
        acc = v && rdy;
        e   = acc && ((op == 0 && st != S_IDLE) || ((op == 1 || op == 2) && st != S_OPEN));
        @(posedge clk);
        edge_n++;
        if (r) begin
            model_reset();
        end else if (acc && !e) begin
            case (op)
                0: begin m_open[g][b] = 1'b1; m_tact[g][b] = edge_n; m_row[g][b] = CHW'(rw); end
                1, 2: begin m_col[g][b] = COLW'(cl); m_rdwr[g][b] = (op == 2); end
                default: if (st == S_OPEN) begin m_open[g][b] = 1'b0; m_tpre[g][b] = edge_n; end
            endcase
        end
        s.err = e;
        for (int i = 0; i < NBG; i++)
            for (int j = 0; j < NBA; j++)
                s.open[i][j] = (mstat(i, j) == S_OPEN);
        s.row = m_row; s.col = m_col; s.rdwr = m_rdwr;
        q.push_back(s);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, a);
    endtask

    // Monitor: compares DUT outputs after each edge against the oldest queued expectation
    initial begin
        snap_t s;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                s = q.pop_front();
                chk("err",       256'(err),       256'(s.err));
                chk("bank_open", 256'(bank_open), 256'(s.open));
                chk("row",       256'(row),       256'(s.row));
                chk("column",    256'(column),    256'(s.col));
                chk("rd_o_wr",   256'(rd_o_wr),   256'(s.rdwr));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit a;
        int tries;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 1, 0, 0, 0, 3, 0, a);
        step(1, 0, 0, 0, 0, 0, 0, a);

        // Activate bg1 ba2 row 5 and watch it open after TRCD
        step(0, 1, 0, 1, 2, 5, 0, a);
        idle(4);

        // Open 0/0, write column 0x3FF then read column 7
        step(0, 1, 0, 0, 0, 9, 0, a);
        idle(3);
        step(0, 1, 2, 0, 0, 0, 10'h3FF, a);
        step(0, 1, 1, 0, 0, 0, 7, a);
        idle(1);

        // PRE two cycles after ACT is held off by tRAS, then closes after TRP
        step(0, 1, 0, 2, 1, 17, 0, a);
        idle(1);
        tries = 0;
        do begin
            step(0, 1, 3, 2, 1, 0, 0, a);
            tries++;
        end while (!a && tries < 12);
        idle(4);

        // Illegal commands: RD to idle bank, ACT to open bank
        step(0, 1, 1, 3, 0, 0, 5, a);
        step(0, 1, 0, 0, 0, 1, 0, a);
        idle(1);
        // PRE to idle bank is a silent no-op
        step(0, 1, 3, 3, 2, 0, 0, a);

        // Back-to-back ACTs to different banks, then reset mid-activation
        step(1, 0, 0, 0, 0, 0, 0, a);
        step(0, 1, 0, 0, 0, 4, 0, a);
        step(0, 1, 0, 3, 3, 30, 0, a);
        idle(3);
        step(0, 1, 0, 1, 1, 11, 0, a);
        step(0, 0, 0, 0, 0, 0, 0, a);
        step(1, 1, 0, 1, 1, 11, 0, a);
        step(0, 1, 0, 1, 1, 12, 0, a);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 1200; i++) begin
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 1023)), a);
        end
        idle(2);

        @(posedge clk);
        #4;
        chk("queue_drain", 256'(q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bank_cmd_sequencer.md
BANK_CMD_SEQUENCER -- requirements
Module: bank_cmd_sequencer

Interface
REQ-001 SHALL have parameter BGWIDTH, default 2, bank-group index width; BANKGROUPS = 2**BGWIDTH.
REQ-002 SHALL have parameter BAWIDTH, default 2, bank index width; BANKSPERGROUP = 2**BAWIDTH.
REQ-003 SHALL have parameter COLWIDTH, default 10, column address width.
REQ-004 SHALL have parameter CHWIDTH, default 5, row address width.
REQ-005 SHALL have parameters TRCD, default 3; TRP, default 3; TRAS, default 6; all in clk cycles, each >= 1.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1), request handshake.
REQ-009 SHALL have port cmd_op, input, 2, command: 0 ACT, 1 RD, 2 WR, 3 PRE.
REQ-010 SHALL have ports cmd_bg (input, BGWIDTH), cmd_ba (input, BAWIDTH), cmd_row (input, CHWIDTH) and cmd_col (input, COLWIDTH), command target.
REQ-011 SHALL have port rd_o_wr, output, 1 per [BANKGROUPS][BANKSPERGROUP], 0 read / 1 write, for the bank array.
REQ-012 SHALL have ports row (output, CHWIDTH) and column (output, COLWIDTH), each per [BANKGROUPS][BANKSPERGROUP], address to the bank array.
REQ-013 SHALL have port bank_open, output, 1 per [BANKGROUPS][BANKSPERGROUP], high while the bank is in ACTIVE.
REQ-014 SHALL have port err, output, 1, one-cycle pulse flagging an illegal accepted command.

Function
REQ-015 SHALL hold one FSM per bank with states IDLE, ACTIVATING, ACTIVE, PRECHARGING.
REQ-016 SHALL accept a command when cmd_valid and cmd_ready are both high; state, row, column and rd_o_wr updates SHALL be visible on the following cycle.
REQ-017 SHALL drive cmd_ready combinationally low when the target bank is in ACTIVATING or PRECHARGING, or when the command is PRE and the tRAS counter is nonzero; otherwise high.
REQ-018 ACT to IDLE bank SHALL latch cmd_row into row, enter ACTIVATING for TRCD cycles, then enter ACTIVE, and load the tRAS counter with TRAS.
REQ-019 RD/WR to ACTIVE bank SHALL latch cmd_col into column and set rd_o_wr to 0 (RD) or 1 (WR); the state SHALL stay ACTIVE.
REQ-020 PRE to ACTIVE bank SHALL enter PRECHARGING for TRP cycles, then IDLE. PRE to IDLE SHALL be a legal no-op.
REQ-021 ACT to a non-IDLE bank, and RD/WR to a non-ACTIVE bank, SHALL be accepted, SHALL leave all state unchanged, and SHALL pulse err.
REQ-022 Timing counters SHALL count down saturating at 0, with width clog2(max(TRCD,TRP,TRAS)+1); the tRAS counter SHALL run during ACTIVATING and ACTIVE.
REQ-023 Banks not targeted SHALL keep their FSMs and counters advancing independently; only one command SHALL be accepted per cycle.
REQ-024 row, column and rd_o_wr SHALL hold their last value until the next ACT (row) or RD/WR (column, rd_o_wr) to that bank.

Reset
REQ-025 On rst high, all FSMs SHALL go to IDLE, all counters SHALL clear to 0, row, column, rd_o_wr, bank_open and err SHALL be 0, and no command SHALL be accepted that cycle.
REQ-026 Reset mid-ACTIVATING or mid-PRECHARGING SHALL abort the operation with no residual timing.

Configuration
REQ-027 Macro BANK_CMD_SEQUENCER_STATS_EN, when defined, SHALL add outputs act_cnt, rd_cnt, wr_cnt and err_cnt (32 bits each, wrapping, reset to 0) counting accepted ACT, legal RD, legal WR and err pulses; without it these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Package sched_pkg SHALL hold the cmd_op enum, the bank-state enum and the default timing constants.
REQ-029 The per-bank FSM with its counters SHALL be sub-module bank_fsm, instantiated BANKGROUPS x BANKSPERGROUP times by generate.

Verification
REQ-030 ACT bg1 ba2 row 5 -> bank_open[1][2] rises exactly 3 cycles after the state becomes ACTIVATING, and row[1][2]=5.
REQ-031 With bank 0/0 open, WR col 0x3FF then RD col 7 -> column[0][0]=0x3FF with rd_o_wr=1, then column[0][0]=7 with rd_o_wr=0.
REQ-032 PRE issued 2 cycles after ACT -> cmd_ready stays low until the tRAS counter reaches 0; the bank then returns to IDLE 3 cycles after PRE is accepted.
REQ-033 RD to an IDLE bank -> accepted, one err pulse, no output change; ACT to an ACTIVE bank -> one err pulse, row unchanged.
REQ-034 ACT bank 0/0, and next cycle ACT bank 3/3 -> both accepted back-to-back and both open after TRCD; rst asserted mid-ACTIVATING -> all outputs 0 the next cycle.
